// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - buffers tagged ALU requests and sequences them through an 8-bit ALU
// One operation in flight: pop, hold operands for the ALU's register stage, capture, respond.
module alu_op_sequencer #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [7:0]              cmd_a,
   input  logic [7:0]              cmd_b,
   input  logic [3:0]              cmd_sel,
   input  logic [TAG_W-1:0]        cmd_tag,
   output logic [7:0]              alu_a,
   output logic [7:0]              alu_b,
   output logic [3:0]              alu_sel,
   input  logic [7:0]              alu_out,
   input  logic                    alu_carry,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [7:0]              rsp_data,
   output logic                    rsp_carry,
   output logic [TAG_W-1:0]        rsp_tag,
   output logic                    rsp_err,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  fifo_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [7:0]       a;
      logic [7:0]       b;
      logic [3:0]       sel;
      logic [TAG_W-1:0] tag;
      logic             err;
   } entry_t;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

   entry_t           mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   state_t           state, state_next;
   logic             push, pop, empty;
   logic [TAG_W-1:0] pend_tag;
   logic             pend_err;
   entry_t           head;

   assign empty      = (count == '0);
   assign cmd_ready  = (count != CW'(DEPTH));
   assign push       = cmd_valid && cmd_ready;
   assign busy       = (state != IDLE) || !empty;
   assign fifo_count = count;
   assign head       = mem[rd_ptr];

   // Error is decided at push so the FIFO carries it alongside the operands.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, sel: cmd_sel, tag: cmd_tag,
                          err: (cmd_sel > 4'd3) || (cmd_sel == 4'd3 && cmd_b == 8'd0)};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE:   state_next = CAPTURE;
         CAPTURE: state_next = RESP;
         RESP: begin
            if (rsp_ready) begin
               if (!empty) begin
                  pop        = 1'b1;
                  state_next = ISSUE;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         pend_tag  <= '0;
         pend_err  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         rsp_tag   <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_next;
         if (pop) begin
            alu_a    <= head.a;
            alu_b    <= head.b;
            alu_sel  <= head.sel;
            pend_tag <= head.tag;
            pend_err <= head.err;
         end
         if (state == CAPTURE) begin
            // Errored ops return a fixed pattern, masking whatever the ALU produced.
            rsp_valid <= 1'b1;
            rsp_data  <= pend_err ? 8'hFF : alu_out;
            rsp_carry <= pend_err ? 1'b0 : alu_carry;
            rsp_tag   <= pend_tag;
            rsp_err   <= pend_err;
         end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Upstream command stage for the 8-bit ALU. Accepts tagged operation requests over a valid/ready interface, buffers them in a small FIFO, and drives the ALU operand/select inputs one operation at a time. It then captures the ALU's registered result one cycle later and returns it with the request tag and an error flag over a valid/ready response interface. One operation in flight; no reordering.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- TAG_W, 4, width of request/response tag
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  request present
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_a, cmd_b  in  8 each  operands
- cmd_sel  in  4  op select: 0 add, 1 sub, 2 mul, 3 div, others illegal
- cmd_tag  in  TAG_W  request tag, returned unchanged
- alu_a, alu_b  out  8 each  registered operands to ALU
- alu_sel  out  4  registered select to ALU
- alu_out  in  8  ALU registered result
- alu_carry  in  1  ALU registered carry
- rsp_valid  out  1  response present
- rsp_ready  in  1  downstream accepts response
- rsp_data  out  8  result
- rsp_carry  out  1  carry
- rsp_tag  out  TAG_W  tag of the completed request
- rsp_err  out  1  illegal select or divide by zero
- busy  out  1  state != IDLE or FIFO non-empty
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries

## Operation
- Reset (reset_n low, asynchronous): FIFO emptied, fifo_count=0, state IDLE, alu_a=alu_b=0, alu_sel=0, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_tag=0, rsp_err=0, busy=0, cmd_ready=1 once reset releases. In-flight and buffered requests are discarded.
- Push on the edge with cmd_valid && cmd_ready. A push when full cannot occur because cmd_ready=0. A push and a pop in the same edge leave fifo_count unchanged.
- FIFO entry holds {a, b, sel, tag, err}. err is computed at push: (sel>3) || (sel==3 && b==0).
- State machine:
  - IDLE: if FIFO non-empty, pop and load alu_a/alu_b/alu_sel and a pending tag/err; go to ISSUE.
  - ISSUE: operands held stable; the ALU registers its result at this edge; go to CAPTURE.
  - CAPTURE: load rsp_data, rsp_carry, rsp_tag, rsp_err; set rsp_valid; go to RESP.
    - If err: rsp_data=8'hFF and rsp_carry=0, regardless of alu_out/alu_carry. This also masks an undefined divide-by-zero result.
    - Otherwise: rsp_data=alu_out and rsp_carry=alu_carry.
  - RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On an edge with rsp_ready:
    - clear rsp_valid;
    - if FIFO non-empty, pop/load operands and go to ISSUE;
    - else go to IDLE.
- alu_a/alu_b/alu_sel change only on a pop edge; they keep their last values otherwise.
- Arithmetic is performed entirely by the ALU. Results are 8-bit truncated; sub wraps modulo 256; mul returns the low 8 bits.
- rsp_valid, once asserted, does not drop until accepted.

## Timing
- Empty FIFO, IDLE: request pushed at edge 0 → pop/operands at edge 1 → ALU result at edge 2 → rsp_valid=1 after edge 3. Latency is 3 cycles.
- Back-to-back with rsp_ready held high: one response every 3 cycles.
- Response stall: the FIFO keeps accepting until full, then cmd_ready=0 in the cycle after the filling push.
- cmd_ready, busy and fifo_count are registered-state derived. There is no combinational path from cmd_valid or rsp_ready to any output.
- reset_n asserted mid-operation: all outputs go to reset values immediately, without waiting for a clock edge.

## Test plan
- Single add a=8'hF0, b=8'h20, sel=0, tag=5 → 3 cycles later: rsp_data=8'h10, rsp_carry=1, rsp_tag=5, rsp_err=0.
- Four commands back-to-back (sub 5-7, mul 16×17, div 200/7, add 1+1), rsp_ready=1 → responses in order: 8'hFE, 8'h10, 8'h1C, 8'h02, spaced 3 cycles apart.
- Div by zero a=9, b=0, sel=3, and illegal sel=4'hA → both return rsp_data=8'hFF, rsp_carry=0, rsp_err=1.
- rsp_ready=0 while pushing DEPTH+1 commands:
  - cmd_ready falls after the FIFO fills, with fifo_count=DEPTH;
  - the first response is held stable;
  - releasing rsp_ready drains all requests in order with correct tags.
- reset_n pulsed low during CAPTURE with 2 entries queued → rsp_valid=0 and fifo_count=0 immediately; after release, no stale response appears.
- Push and pop on the same edge at fifo_count=2 → fifo_count stays 2.
